// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle: upstream EX entry, downstream MEM handshake and
// exception report. The stage itself uses the slave modport.
interface ex_mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [7:0]  ex_status;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_ovf_trap;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [7:0]  mem_status;
  logic [4:0]  mem_rd;
  logic [31:0] mem_store_data;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;

  logic        exc_valid;
  logic [31:0] exc_epc;
  logic [1:0]  exc_cause;

  logic        flush;

  modport master (
    output ex_valid, ex_result, ex_status, ex_pc, ex_rd, ex_store_data,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_trap,
           mem_ready, flush,
    input  ex_ready, mem_valid, mem_result, mem_status, mem_rd, mem_store_data,
           mem_reg_write, mem_mem_read, mem_mem_write,
           exc_valid, exc_epc, exc_cause
  );

  modport slave (
    input  ex_valid, ex_result, ex_status, ex_pc, ex_rd, ex_store_data,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_trap,
           mem_ready, flush,
    output ex_ready, mem_valid, mem_result, mem_status, mem_rd, mem_store_data,
           mem_reg_write, mem_mem_read, mem_mem_write,
           exc_valid, exc_epc, exc_cause
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer (main + skid).
// Classifies overflow / misaligned load / misaligned store at accept time,
// squashes side effects of excepting entries and drops younger entries until
// a flush clears the pending exception.
module ex_mem_stage (
  input  logic               clk,
  input  logic               rst_n,
  ex_mem_stage_if.slave      bus
);

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_OVF   = 2'b01,
    CAUSE_LOAD  = 2'b10,
    CAUSE_STORE = 2'b11
  } cause_e;

  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  status;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] store_data;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        exc;
    cause_e      cause;
  } entry_t;

  entry_t main_q, main_n;
  entry_t skid_q, skid_n;
  entry_t in_entry;
  logic   main_valid_q, main_valid_n;
  logic   skid_valid_q, skid_valid_n;
  logic   exc_pending_q, exc_pending_n;
  logic   ex_ready_q, ex_ready_n;
  logic   take;
  logic   xfer;

  // Accepts while an exception is pending are consumed but never stored.
  assign take = bus.ex_valid && ex_ready_q && !exc_pending_q;
  assign xfer = main_valid_q && bus.mem_ready;

  // Build the incoming entry: classify the exception and squash side effects.
  always_comb begin
    in_entry            = '0;
    in_entry.result     = bus.ex_result;
    in_entry.status     = bus.ex_status;
    in_entry.pc         = bus.ex_pc;
    in_entry.rd         = bus.ex_rd;
    in_entry.store_data = bus.ex_store_data;
    in_entry.reg_write  = bus.ex_reg_write;
    in_entry.mem_read   = bus.ex_mem_read;
    in_entry.mem_write  = bus.ex_mem_write;
    in_entry.cause      = CAUSE_NONE;
    if (bus.ex_ovf_trap && bus.ex_status[6])
      in_entry.cause = CAUSE_OVF;
    else if (bus.ex_mem_read && bus.ex_status[3])
      in_entry.cause = CAUSE_LOAD;
    else if (bus.ex_mem_write && bus.ex_status[3])
      in_entry.cause = CAUSE_STORE;
    in_entry.exc = (in_entry.cause != CAUSE_NONE);
    if (in_entry.exc) begin
      in_entry.reg_write = 1'b0;
      in_entry.mem_read  = 1'b0;
      in_entry.mem_write = 1'b0;
    end
  end

  // Next-state for the two entries, the pending-exception flag and ex_ready.
  always_comb begin
    main_n        = main_q;
    skid_n        = skid_q;
    main_valid_n  = main_valid_q;
    skid_valid_n  = skid_valid_q;
    exc_pending_n = exc_pending_q;
    if (bus.flush) begin
      main_valid_n  = 1'b0;
      skid_valid_n  = 1'b0;
      exc_pending_n = 1'b0;
    end else begin
      if (xfer) begin
        // Skid holds the older entry, so it refills main ahead of any accept;
        // a real accept cannot coincide because ex_ready is low while skid is
        // full (except under exc_pending, where accepts are discarded anyway).
        if (skid_valid_q) begin
          main_n       = skid_q;
          skid_valid_n = 1'b0;
        end else if (take) begin
          main_n = in_entry;
        end else begin
          main_valid_n = 1'b0;
        end
      end else if (take) begin
        if (!main_valid_q) begin
          main_n       = in_entry;
          main_valid_n = 1'b1;
        end else begin
          skid_n       = in_entry;
          skid_valid_n = 1'b1;
        end
      end
      if (take && in_entry.exc)
        exc_pending_n = 1'b1;
    end
    // Registered ready: low only when skid will be full and entries still count.
    ex_ready_n = exc_pending_n || !skid_valid_n;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      exc_pending_q <= 1'b0;
      ex_ready_q    <= 1'b1;
    end else begin
      main_q        <= main_n;
      skid_q        <= skid_n;
      main_valid_q  <= main_valid_n;
      skid_valid_q  <= skid_valid_n;
      exc_pending_q <= exc_pending_n;
      ex_ready_q    <= ex_ready_n;
    end
  end

  assign bus.ex_ready       = ex_ready_q;
  assign bus.mem_valid      = main_valid_q;
  assign bus.mem_result     = main_q.result;
  assign bus.mem_status     = main_q.status;
  assign bus.mem_rd         = main_q.rd;
  assign bus.mem_store_data = main_q.store_data;
  assign bus.mem_reg_write  = main_q.reg_write;
  assign bus.mem_mem_read   = main_q.mem_read;
  assign bus.mem_mem_write  = main_q.mem_write;
  assign bus.exc_valid      = main_valid_q && main_q.exc;
  assign bus.exc_epc        = main_q.pc;
  assign bus.exc_cause      = (main_valid_q && main_q.exc) ? main_q.cause : CAUSE_NONE;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, streaming, backpressure,
// exception classification/discard, flush and mid-stream reset.
module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_mem_stage_if bus_if ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bus_if.ex_valid      = 1'b0;
    bus_if.ex_result     = '0;
    bus_if.ex_status     = '0;
    bus_if.ex_pc         = '0;
    bus_if.ex_rd         = '0;
    bus_if.ex_store_data = '0;
    bus_if.ex_reg_write  = 1'b0;
    bus_if.ex_mem_read   = 1'b0;
    bus_if.ex_mem_write  = 1'b0;
    bus_if.ex_ovf_trap   = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] result, input logic [7:0] status,
                        input logic [31:0] pc, input logic rw, input logic mr,
                        input logic mw, input logic ovf);
    bus_if.ex_valid     = 1'b1;
    bus_if.ex_result    = result;
    bus_if.ex_status    = status;
    bus_if.ex_pc        = pc;
    bus_if.ex_reg_write = rw;
    bus_if.ex_mem_read  = mr;
    bus_if.ex_mem_write = mw;
    bus_if.ex_ovf_trap  = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ex();
    bus_if.mem_ready = 1'b0;
    bus_if.flush     = 1'b0;
    tick();
    tick();
    checks++; if (bus_if.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0b want 0", bus_if.mem_valid); end
    checks++; if (bus_if.ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %0b want 1", bus_if.ex_ready); end
    checks++; if (bus_if.exc_valid !== 1'b0 || bus_if.exc_cause !== 2'b00) begin errors++; $display("FAIL reset_exc got v=%0b c=%0b want v=0 c=00", bus_if.exc_valid, bus_if.exc_cause); end
    checks++; if (bus_if.mem_result !== 32'h0 || bus_if.exc_epc !== 32'h0 || bus_if.mem_store_data !== 32'h0) begin errors++; $display("FAIL reset_data got res=%h epc=%h sd=%h want 0", bus_if.mem_result, bus_if.exc_epc, bus_if.mem_store_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    bus_if.mem_ready = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      set_ex(i, 8'h00, 32'h100 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_result !== i) begin errors++; $display("FAIL stream_out%0d got v=%0b res=%h want v=1 res=%h", i, bus_if.mem_valid, bus_if.mem_result, i); end
      checks++; if (bus_if.ex_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %0b want 1", i, bus_if.ex_ready); end
    end
    clear_ex();
    tick();
    checks++; if (bus_if.mem_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", bus_if.mem_valid); end
  endtask

  task automatic test_backpressure();
    bus_if.mem_ready = 1'b0;
    set_ex(32'h10, 8'h00, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_result !== 32'h10 || bus_if.ex_ready !== 1'b1) begin errors++; $display("FAIL bp_a got v=%0b res=%h rdy=%0b want 1 10 1", bus_if.mem_valid, bus_if.mem_result, bus_if.ex_ready); end
    set_ex(32'h20, 8'h00, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.ex_ready !== 1'b0 || bus_if.mem_result !== 32'h10) begin errors++; $display("FAIL bp_full got rdy=%0b res=%h want 0 10", bus_if.ex_ready, bus_if.mem_result); end
    clear_ex();
    tick();
    checks++; if (bus_if.mem_result !== 32'h10 || bus_if.mem_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%0b res=%h want 1 10", bus_if.mem_valid, bus_if.mem_result); end
    bus_if.mem_ready = 1'b1;
    tick();
    checks++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_result !== 32'h20 || bus_if.ex_ready !== 1'b1) begin errors++; $display("FAIL bp_b got v=%0b res=%h rdy=%0b want 1 20 1", bus_if.mem_valid, bus_if.mem_result, bus_if.ex_ready); end
    tick();
    checks++; if (bus_if.mem_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", bus_if.mem_valid); end
  endtask

  task automatic test_overflow();
    bus_if.mem_ready = 1'b0;
    set_ex(32'h8000_0000, 8'h40, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (bus_if.mem_reg_write !== 1'b0 || bus_if.mem_result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_entry got rw=%0b res=%h want 0 80000000", bus_if.mem_reg_write, bus_if.mem_result); end
    checks++; if (bus_if.exc_valid !== 1'b1 || bus_if.exc_epc !== 32'h400 || bus_if.exc_cause !== 2'b01) begin errors++; $display("FAIL ovf_exc got v=%0b epc=%h c=%0b want 1 400 01", bus_if.exc_valid, bus_if.exc_epc, bus_if.exc_cause); end
    set_ex(32'h55, 8'h00, 32'h404, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.mem_ready = 1'b1;
    tick();
    checks++; if (bus_if.mem_valid !== 1'b0 || bus_if.ex_ready !== 1'b1) begin errors++; $display("FAIL ovf_discard got v=%0b rdy=%0b want 0 1", bus_if.mem_valid, bus_if.ex_ready); end
    tick();
    checks++; if (bus_if.mem_valid !== 1'b0) begin errors++; $display("FAIL ovf_discard2 got %0b want 0", bus_if.mem_valid); end
    clear_ex();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    set_ex(32'h66, 8'h00, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_result !== 32'h66 || bus_if.mem_reg_write !== 1'b1 || bus_if.exc_valid !== 1'b0) begin errors++; $display("FAIL ovf_resume got v=%0b res=%h rw=%0b exc=%0b want 1 66 1 0", bus_if.mem_valid, bus_if.mem_result, bus_if.mem_reg_write, bus_if.exc_valid); end
    clear_ex();
    tick();
  endtask

  task automatic test_addr_error();
    bus_if.mem_ready = 1'b0;
    set_ex(32'h1002, 8'h08, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (bus_if.mem_mem_write !== 1'b0 || bus_if.exc_cause !== 2'b11 || bus_if.exc_valid !== 1'b1 || bus_if.mem_result !== 32'h1002) begin errors++; $display("FAIL store_err got mw=%0b c=%0b v=%0b res=%h want 0 11 1 1002", bus_if.mem_mem_write, bus_if.exc_cause, bus_if.exc_valid, bus_if.mem_result); end
    clear_ex();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    set_ex(32'h1002, 8'h48, 32'h604, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (bus_if.exc_cause !== 2'b01 || bus_if.mem_mem_write !== 1'b0) begin errors++; $display("FAIL store_ovf_prio got c=%0b mw=%0b want 01 0", bus_if.exc_cause, bus_if.mem_mem_write); end
    clear_ex();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    set_ex(32'h2001, 8'h08, 32'h608, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.exc_cause !== 2'b10 || bus_if.mem_mem_read !== 1'b0 || bus_if.mem_reg_write !== 1'b0 || bus_if.exc_epc !== 32'h608) begin errors++; $display("FAIL load_err got c=%0b mr=%0b rw=%0b epc=%h want 10 0 0 608", bus_if.exc_cause, bus_if.mem_mem_read, bus_if.mem_reg_write, bus_if.exc_epc); end
    clear_ex();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    // Misaligned-flag set but no memory op and no trap: not an exception.
    set_ex(32'h3003, 8'h48, 32'h60c, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.exc_valid !== 1'b0 || bus_if.exc_cause !== 2'b00 || bus_if.mem_reg_write !== 1'b1) begin errors++; $display("FAIL no_exc got v=%0b c=%0b rw=%0b want 0 00 1", bus_if.exc_valid, bus_if.exc_cause, bus_if.mem_reg_write); end
    clear_ex();
    bus_if.mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    bus_if.mem_ready = 1'b0;
    set_ex(32'hA1, 8'h00, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ex(32'hA2, 8'h00, 32'h704, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.ex_ready !== 1'b0) begin errors++; $display("FAIL flush_pre got rdy=%0b want 0", bus_if.ex_ready); end
    set_ex(32'hA3, 8'h00, 32'h708, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    clear_ex();
    checks++; if (bus_if.mem_valid !== 1'b0 || bus_if.ex_ready !== 1'b1 || bus_if.exc_valid !== 1'b0) begin errors++; $display("FAIL flush got v=%0b rdy=%0b exc=%0b want 0 1 0", bus_if.mem_valid, bus_if.ex_ready, bus_if.exc_valid); end
  endtask

  task automatic test_reset_midstream();
    bus_if.mem_ready = 1'b0;
    set_ex(32'hB1, 8'h00, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ex(32'hB2, 8'h00, 32'h804, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ex(32'hB3, 8'h00, 32'h808, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.mem_ready = 1'b1;
    bus_if.flush     = 1'b1;
    rst_n = 1'b0;
    tick();
    bus_if.flush = 1'b0;
    checks++; if (bus_if.mem_valid !== 1'b0 || bus_if.ex_ready !== 1'b1 || bus_if.exc_valid !== 1'b0 || bus_if.exc_cause !== 2'b00) begin errors++; $display("FAIL rst_mid_ctrl got v=%0b rdy=%0b exc=%0b c=%0b want 0 1 0 00", bus_if.mem_valid, bus_if.ex_ready, bus_if.exc_valid, bus_if.exc_cause); end
    checks++; if (bus_if.mem_result !== 32'h0 || bus_if.mem_reg_write !== 1'b0 || bus_if.exc_epc !== 32'h0) begin errors++; $display("FAIL rst_mid_data got res=%h rw=%0b epc=%h want 0 0 0", bus_if.mem_result, bus_if.mem_reg_write, bus_if.exc_epc); end
    rst_n = 1'b1;
    set_ex(32'h77, 8'hB5, 32'hCAFE_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.ex_rd         = 5'd19;
    bus_if.ex_store_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_result !== 32'h77 || bus_if.mem_status !== 8'hB5) begin errors++; $display("FAIL rst_release got v=%0b res=%h st=%h want 1 77 b5", bus_if.mem_valid, bus_if.mem_result, bus_if.mem_status); end
    checks++; if (bus_if.mem_store_data !== 32'hDEAD_BEEF || bus_if.mem_rd !== 5'd19 || bus_if.exc_epc !== 32'hCAFE_0000) begin errors++; $display("FAIL rst_release_data got sd=%h rd=%0d pc=%h want deadbeef 19 cafe0000", bus_if.mem_store_data, bus_if.mem_rd, bus_if.exc_epc); end
    clear_ex();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_addr_error();
    test_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-002 ex_valid in 1: EX entry valid; ex_ready out 1: block can accept.
REQ-003 ex_result in 32: ALU result, also the load/store address; ex_status in 8: ALU flags [7]=zero, [6]=overflow, [5]=carry, [4]=negative, [3]=low-2-bits-nonzero.
REQ-004 ex_pc in 32; ex_rd in 5; ex_store_data in 32.
REQ-005 ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_trap in 1 each; ex_ovf_trap=1 for trapping add/sub.
REQ-006 mem_valid out 1; mem_ready in 1: downstream handshake.
REQ-007 mem_result out 32, mem_status out 8, mem_rd out 5, mem_store_data out 32, mem_reg_write/mem_mem_read/mem_mem_write out 1 each.
REQ-008 exc_valid out 1, exc_epc out 32, exc_cause out 2 (01 overflow, 10 load address error, 11 store address error).
REQ-009 flush in 1: discard all held state.

Function
REQ-010 Storage SHALL be a two-entry skid buffer: main entry (drives mem_* outputs) and skid entry; each entry holds all ex_* fields plus exc flag and cause.
REQ-011 ex_ready SHALL be registered and equal to NOT skid_valid; it SHALL NOT depend combinationally on mem_ready.
REQ-012 Accept: ex_valid && ex_ready at a rising edge; transfer: mem_valid && mem_ready at a rising edge; mem_valid = main_valid.
REQ-013 Accept into empty main, or into main being transferred the same edge, SHALL load main; latency ex accept -> mem_valid high is 1 cycle.
REQ-014 Accept while main is held (not transferred) SHALL load skid.
REQ-015 Transfer with skid valid SHALL move skid into main and clear skid the same edge; with an accept on that edge the accepted entry is not possible (ex_ready=0).
REQ-016 Entry order SHALL be preserved; no entry SHALL be dropped or duplicated except per REQ-019/REQ-020.
REQ-017 Exception classification at accept, priority order: ex_ovf_trap && ex_status[6] -> cause 01; ex_mem_read && ex_status[3] -> 10; ex_mem_write && ex_status[3] -> 11.
REQ-018 An excepting entry SHALL be stored with reg_write, mem_read, mem_write forced to 0; result, status, pc, rd stored unchanged.
REQ-019 Accepting an excepting entry SHALL set exc_pending; while exc_pending=1, ex_ready SHALL be 1 and accepted entries SHALL be discarded.
REQ-020 exc_valid = main_valid && main_exc; exc_epc = main pc; exc_cause = main cause; exc_cause=00 when exc_valid=0.
REQ-021 flush=1 SHALL on the same edge clear main_valid, skid_valid, exc_pending, and set ex_ready=1; flush overrides accept and transfer at that edge.
REQ-022 Holding mem_ready=0 SHALL keep all mem_* and exc_* outputs stable.
REQ-023 No arithmetic on data fields; all 32-bit fields SHALL pass bit-exact.

Reset
REQ-024 When rst_n=0 at a rising edge: main_valid=0, skid_valid=0, exc_pending=0, ex_ready=1, mem_valid=0, exc_valid=0, exc_cause=00, all data outputs 0.
REQ-025 Reset SHALL override flush, accept and transfer; an entry in flight when reset asserts SHALL be lost.

Verification
REQ-026 Streaming: mem_ready=1, 4 back-to-back entries result 1..4 -> mem_valid from cycle 1, results 1,2,3,4 on consecutive cycles, ex_ready constantly 1.
REQ-027 Backpressure: mem_ready=0, send A=0x10, B=0x20 -> ex_ready=0 after B; raise mem_ready -> A then B out, ex_ready returns 1 after skid drains.
REQ-028 Overflow trap: ex_result=0x80000000, ex_status[6]=1, ex_ovf_trap=1, ex_reg_write=1, pc=0x400 -> mem_reg_write=0, exc_valid=1, exc_epc=0x400, exc_cause=01; next entry discarded until flush.
REQ-029 Address error: ex_mem_write=1, ex_result=0x1002, ex_status[3]=1 -> mem_mem_write=0, exc_cause=11; same with ex_ovf_trap=1 and status[6]=1 -> exc_cause=01.
REQ-030 Flush with both entries full and mem_ready=0 -> next cycle mem_valid=0, ex_ready=1, exc_valid=0.
REQ-031 rst_n=0 mid-stream with skid full -> next cycle all outputs at REQ-024 values; first entry after release appears with 1-cycle latency.
